// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Purpose:
//   Multi-cycle controller for a 1-bit-per-cycle shifter datapath. It executes
//   SLLI / SRLI / SRAI with a full shift amount. The operand, operation and
//   shift amount are captured on an accepted start. The external shifter is
//   then iterated once per clock, with its output fed back into an internal
//   accumulator. Completion is reported with a one-cycle done pulse, and the
//   shifted value is held on result until the next operation completes.
//
// Ports:
//   clk      in   1        system clock, rising edge
//   reset    in   1        asynchronous, active-high reset
//   start    in   1        request, sampled only while not busy
//   op       in   2        01=SLL, 10=SRL, 11=SRA, 00=no shift
//   shamt    in   SHAMT_W  shift amount
//   din      in   WIDTH    operand
//   busy     out  1        high while iterating (state SHIFT)
//   done     out  1        one-cycle pulse, result valid
//   result   out  WIDTH    shifted value, held between operations
//   shf_in   out  WIDTH    shifter data input (the accumulator)
//   shf_sel  out  2        shifter select, op in SHIFT, otherwise 2'b00
//   shf_out  in   WIDTH    shifter output (combinational, same cycle)
// ---------------------------------------------------------------------------
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   shf_in,
  output logic [1:0]         shf_sel,
  input  logic [WIDTH-1:0]   shf_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_SHAMT = WIDTH - 1;

  state_t               r_state;
  state_t               w_nextState;
  logic [WIDTH-1:0]     r_acc;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [1:0]           r_opQ;
  logic [WIDTH-1:0]     r_result;

  logic                 w_accept;
  logic                 w_noShift;
  logic                 w_lastStep;
  logic [SHAMT_W-1:0]   w_shamtClamped;

  // A request is only looked at when the controller is not iterating, so a
  // start raised during SHIFT is simply dropped. An amount beyond the last
  // bit position is limited to WIDTH-1, which keeps the counter in range for
  // any legal parameter pairing.
  always_comb begin
    w_accept       = start && (r_state != SHIFT);
    w_shamtClamped = shamt;
    if ({1'b0, shamt} > (SHAMT_W + 1)'(MAX_SHAMT)) begin
      w_shamtClamped = SHAMT_W'(MAX_SHAMT);
    end
    w_noShift  = (w_shamtClamped == '0) || (op == 2'b00);
    w_lastStep = (r_state == SHIFT) && (r_cnt == SHAMT_W'(1));
  end

  // State register. Reset aborts any operation in flight and returns the
  // controller to IDLE, so no done pulse is produced for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. IDLE and DONE both behave as "ready", which allows a
  // fresh request to be issued in the same cycle as the previous done pulse.
  // Zero-length or no-op requests go straight to DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_nextState = w_noShift ? DONE : SHIFT;
        end else begin
          w_nextState = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == SHAMT_W'(1)) begin
          w_nextState = DONE;
        end else begin
          w_nextState = SHIFT;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. On accept the operand, operation and amount are
  // captured. During SHIFT the accumulator takes the shifter output and the
  // counter steps down; the counter is never decremented below one inside
  // SHIFT because the final step moves to DONE. result is written only on
  // entry to DONE, with the value the accumulator holds in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_opQ    <= 2'b00;
      r_result <= '0;
    end else if (w_accept) begin
      r_acc <= din;
      r_opQ <= op;
      r_cnt <= w_shamtClamped;
      if (w_noShift) begin
        r_result <= din;
      end
    end else if (r_state == SHIFT) begin
      r_acc <= shf_out;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - SHAMT_W'(1);
      end
      if (w_lastStep) begin
        r_result <= shf_out;
      end
    end
  end

  // Output decode. Status flags come straight from the state. The shifter
  // select is forced to pass-through outside SHIFT so the datapath is idle.
  always_comb begin
    busy    = (r_state == SHIFT);
    done    = (r_state == DONE);
    shf_sel = (r_state == SHIFT) ? r_opQ : 2'b00;
    shf_in  = r_acc;
    result  = r_result;
  end

endmodule
